// File: rtl/game_pkg.sv
// Shared types and constants for the snake game plot path: grid geometry,
// field widths, the named colours and the plot arbiter state encoding.
package game_pkg;

    localparam int GRID_DIM = 16;
    localparam int CELL_W   = 4;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
    localparam logic [COLOUR_W-1:0] RED   = 3'b100;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CLEAR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/plot_arbiter_if.sv
// Bundle between the game-logic requesters / clear control on one side,
// the cell plotter on the other, and the plot arbiter in the middle.
// The arbiter uses the slave view; the surrounding logic uses master.
interface plot_arbiter_if
    import game_pkg::*;
#(
    parameter int N = 4
) ();

    // requester side
    logic [N-1:0]          req;
    logic [CELL_W*N-1:0]   req_x;
    logic [CELL_W*N-1:0]   req_y;
    logic [COLOUR_W*N-1:0] req_colour;
    logic [N-1:0]          req_wait;

    // board clear control
    logic                  clear_start;
    logic [COLOUR_W-1:0]   clear_colour;
    logic                  clear_busy;
    logic                  clear_done;

    // cell plotter side
    logic                  plot_req;
    logic [CELL_W-1:0]     plot_x;
    logic [CELL_W-1:0]     plot_y;
    logic [COLOUR_W-1:0]   plot_colour;
    logic                  plot_waitrequest;

    modport slave (
        input  req, req_x, req_y, req_colour,
        output req_wait,
        input  clear_start, clear_colour,
        output clear_busy, clear_done,
        output plot_req, plot_x, plot_y, plot_colour,
        input  plot_waitrequest
    );

    modport master (
        output req, req_x, req_y, req_colour,
        input  req_wait,
        output clear_start, clear_colour,
        input  clear_busy, clear_done,
        input  plot_req, plot_x, plot_y, plot_colour,
        output plot_waitrequest
    );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the first requester with req
// high, searching from last+1 upwards and wrapping modulo N.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);

    logic [IW-1:0] idx_s;

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        grant = {IW{1'b0}};
        valid = 1'b0;
        idx_s = {IW{1'b0}};
        for (int k = 1; k <= N; k++) begin
            idx_s = IW'((int'(last) + k) % N);
            if (!valid && req[idx_s]) begin
                grant = idx_s;
                valid = 1'b1;
            end else begin
                grant = grant;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the single grid cell plotter between N game-logic requesters and
// a board-clear sequencer. Requesters are served round-robin with one IDLE
// arbitration cycle between grants; a pending clear wins every arbitration
// point and then sweeps all cells row-major with one latched colour.
module plot_arbiter
    import game_pkg::*;
#(
    parameter int N    = 4,
    parameter int GRID = GRID_DIM
) (
    input  logic          clk,
    input  logic          rst,
    plot_arbiter_if.slave bus
);

    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int AW    = $clog2(GRID);
    localparam int CNT_W = 2 * AW;
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
    localparam logic [IW-1:0]    RR_INIT  = IW'(N - 1);

    arb_state_t          state_r;
    logic [IW-1:0]       grant_r;
    logic [IW-1:0]       rr_last_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [COLOUR_W-1:0] clr_colour_r;
    logic                pending_r;
    logic                busy_r;
    logic                done_r;

    logic [IW-1:0]       pick_s;
    logic                pick_valid_s;
    logic                start_ok_s;
    logic                accept_s;
    logic                issue_accept_s;
    logic                plot_req_s;
    logic [CELL_W-1:0]   plot_x_s;
    logic [CELL_W-1:0]   plot_y_s;
    logic [COLOUR_W-1:0] plot_colour_s;
    logic [N-1:0]        req_wait_s;

    // Unpacked views of each requester's fields so the grant can index them.
    logic [CELL_W-1:0]   fx_s [N];
    logic [CELL_W-1:0]   fy_s [N];
    logic [COLOUR_W-1:0] fc_s [N];

    for (genvar g = 0; g < N; g++) begin : g_field
        assign fx_s[g] = bus.req_x[g*CELL_W +: CELL_W];
        assign fy_s[g] = bus.req_y[g*CELL_W +: CELL_W];
        assign fc_s[g] = bus.req_colour[g*COLOUR_W +: COLOUR_W];
    end

    rr_select #(
        .N  (N),
        .IW (IW)
    ) u_rr_select (
        .req   (bus.req),
        .last  (rr_last_r),
        .grant (pick_s),
        .valid (pick_valid_s)
    );

    // A new clear is only taken when none is pending or running.
    assign start_ok_s     = bus.clear_start && !busy_r;
    assign accept_s       = plot_req_s && !bus.plot_waitrequest;
    assign issue_accept_s = (state_r == ISSUE) && accept_s;

    // Present either the granted requester's cell or the current sweep cell.
    always_comb begin
        plot_req_s    = 1'b0;
        plot_x_s      = {CELL_W{1'b0}};
        plot_y_s      = {CELL_W{1'b0}};
        plot_colour_s = {COLOUR_W{1'b0}};
        case (state_r)
            ISSUE: begin
                plot_req_s    = 1'b1;
                plot_x_s      = fx_s[grant_r];
                plot_y_s      = fy_s[grant_r];
                plot_colour_s = fc_s[grant_r];
            end
            CLEAR: begin
                plot_req_s    = 1'b1;
                plot_x_s      = CELL_W'(cnt_r[AW-1:0]);
                plot_y_s      = CELL_W'(cnt_r[CNT_W-1:AW]);
                plot_colour_s = clr_colour_r;
            end
            default: begin
                plot_req_s    = 1'b0;
                plot_x_s      = {CELL_W{1'b0}};
                plot_y_s      = {CELL_W{1'b0}};
                plot_colour_s = {COLOUR_W{1'b0}};
            end
        endcase
    end

    // A requester stops waiting in the very cycle its transfer is accepted.
    always_comb begin
        req_wait_s = bus.req;
        if (issue_accept_s) begin
            req_wait_s[grant_r] = 1'b0;
        end else begin
            req_wait_s = bus.req;
        end
    end

    // Arbitration FSM with the clear sweep counter and clear status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= {IW{1'b0}};
            rr_last_r    <= RR_INIT;
            cnt_r        <= {CNT_W{1'b0}};
            clr_colour_r <= BLACK;
            pending_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start_ok_s) begin
                clr_colour_r <= bus.clear_colour;
                busy_r       <= 1'b1;
                pending_r    <= 1'b1;
            end else begin
                clr_colour_r <= clr_colour_r;
            end
            case (state_r)
                IDLE: begin
                    // A clear pre-empts all requesters at the arbitration point.
                    if (pending_r || start_ok_s) begin
                        state_r   <= CLEAR;
                        cnt_r     <= {CNT_W{1'b0}};
                        pending_r <= 1'b0;
                    end else if (pick_valid_s) begin
                        grant_r <= pick_s;
                        state_r <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (accept_s) begin
                        rr_last_r <= grant_r;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                CLEAR: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == CNT_LAST) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= CLEAR;
                        end
                    end else begin
                        state_r <= CLEAR;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.plot_req    = plot_req_s;
    assign bus.plot_x      = plot_x_s;
    assign bus.plot_y      = plot_y_s;
    assign bus.plot_colour = plot_colour_s;
    assign bus.req_wait    = req_wait_s;
    assign bus.clear_busy  = busy_r;
    assign bus.clear_done  = done_r;

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: directed scenarios plus a random
// phase, every cycle compared against a transaction-level reference model.
module tb_plot_arbiter;
    import game_pkg::*;

    localparam int N     = 4;
    localparam int BUSY  = 36;
    localparam int CELLS = GRID_DIM * GRID_DIM;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running system clock.
    always #5 clk = ~clk;

    plot_arbiter_if #(.N(N)) bus ();

    plot_arbiter #(.N(N), .GRID(GRID_DIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // staged stimulus, applied just after the next rising edge
    logic [N-1:0]   s_req       = '0;
    logic [4*N-1:0] s_x         = '0;
    logic [4*N-1:0] s_y         = '0;
    logic [3*N-1:0] s_col       = '0;
    logic           s_clr_start = 1'b0;
    logic [2:0]     s_clr_col   = 3'd0;
    logic           s_rst       = 1'b0;
    bit   [N-1:0]   persist     = '0;
    bit             rand_mode   = 1'b0;

    // plotter model
    int busy_len = BUSY;
    int plot_cnt = 0;

    // reference model: who owns the plotter and where the sweep is
    bit         m_valid = 1'b0;
    int         m_owner;
    bit         m_clearing;
    int         m_pos;
    bit         m_pend;
    bit         m_busy;
    bit         m_done;
    int         m_last;
    logic [2:0] m_col;

    // observed outputs of the current cycle
    logic       obs_req, obs_busy, obs_done, obs_wr;
    logic [3:0] obs_x, obs_y;
    logic [2:0] obs_col;
    logic [N-1:0] obs_wait;

    // statistics
    int cyc = 0;
    int acc_total, clr_acc, done_cnt, done_cyc, last_clr_cyc, clr_col_mask;
    int first_clr_x, first_clr_y, last_clr_x, last_clr_y, plot_req_cycles;
    int who_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b1;
        m_owner    = -1;
        m_clearing = 1'b0;
        m_pos      = 0;
        m_pend     = 1'b0;
        m_busy     = 1'b0;
        m_done     = 1'b0;
        m_last     = N - 1;
        m_col      = 3'd0;
    endtask

    function automatic int q_at(input int k);
        if (k < who_q.size()) return who_q[k];
        return -1;
    endfunction

    function automatic int stat(input int kind);
        case (kind)
            0:       return acc_total;
            1:       return clr_acc;
            2:       return done_cnt;
            default: return who_q.size();
        endcase
    endfunction

    task automatic cycle();
        logic [N-1:0] e_wait;
        logic         e_req, e_acc, nxt_done;
        logic [3:0]   e_x, e_y;
        logic [2:0]   e_col;
        bit           start_ok, took;
        int           who;
        @(posedge clk);
        #1;
        rst                  = s_rst;
        bus.req              = s_req;
        bus.req_x            = s_x;
        bus.req_y            = s_y;
        bus.req_colour       = s_col;
        bus.clear_start      = s_clr_start;
        bus.clear_colour     = s_clr_col;
        obs_wr               = (plot_cnt > 0);
        bus.plot_waitrequest = obs_wr;
        #3;
        obs_req  = bus.plot_req;
        obs_x    = bus.plot_x;
        obs_y    = bus.plot_y;
        obs_col  = bus.plot_colour;
        obs_wait = bus.req_wait;
        obs_busy = bus.clear_busy;
        obs_done = bus.clear_done;
        cyc++;

        e_acc = 1'b0;
        if (m_valid) begin
            e_req = m_clearing || (m_owner >= 0);
            if (m_clearing) begin
                e_x   = 4'(m_pos % GRID_DIM);
                e_y   = 4'(m_pos / GRID_DIM);
                e_col = m_col;
            end else if (m_owner >= 0) begin
                e_x   = s_x[m_owner*4 +: 4];
                e_y   = s_y[m_owner*4 +: 4];
                e_col = s_col[m_owner*3 +: 3];
            end else begin
                e_x   = 4'd0;
                e_y   = 4'd0;
                e_col = 3'd0;
            end
            e_acc = e_req && !obs_wr;
            for (int i = 0; i < N; i++)
                e_wait[i] = s_req[i] && !(e_acc && !m_clearing && (m_owner == i));
            check_val("plot_req",    32'(obs_req),  32'(e_req));
            check_val("plot_x",      32'(obs_x),    32'(e_x));
            check_val("plot_y",      32'(obs_y),    32'(e_y));
            check_val("plot_colour", 32'(obs_col),  32'(e_col));
            check_val("req_wait",    32'(obs_wait), 32'(e_wait));
            check_val("clear_busy",  32'(obs_busy), 32'(m_busy));
            check_val("clear_done",  32'(obs_done), 32'(m_done));
        end

        // plotter behaviour and transfer log, driven by what the DUT shows
        if (obs_req === 1'b1 && obs_wr === 1'b0) begin
            acc_total++;
            who = -1;
            for (int i = 0; i < N; i++)
                if (s_req[i] && obs_wait[i] === 1'b0) who = i;
            if (who < 0) begin
                if (clr_acc == 0) begin
                    first_clr_x = int'(obs_x);
                    first_clr_y = int'(obs_y);
                end
                clr_acc++;
                last_clr_x   = int'(obs_x);
                last_clr_y   = int'(obs_y);
                last_clr_cyc = cyc;
                clr_col_mask = clr_col_mask | (1 << obs_col);
            end else begin
                who_q.push_back(who);
            end
            plot_cnt = busy_len;
        end else if (plot_cnt > 0) begin
            plot_cnt--;
        end
        if (obs_req === 1'b1) plot_req_cycles++;
        if (obs_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end

        // advance the reference model to the next cycle
        if (s_rst) begin
            model_reset();
        end else if (m_valid) begin
            start_ok = s_clr_start && !m_busy;
            took     = 1'b0;
            nxt_done = 1'b0;
            if (m_clearing) begin
                if (e_acc) begin
                    m_pos++;
                    if (m_pos == CELLS) begin
                        m_clearing = 1'b0;
                        m_busy     = 1'b0;
                        nxt_done   = 1'b1;
                    end
                end
            end else if (m_owner >= 0) begin
                if (e_acc) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (m_pend || start_ok) begin
                m_clearing = 1'b1;
                m_pos      = 0;
                m_pend     = 1'b0;
                took       = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (m_owner < 0 && s_req[(m_last + k) % N]) m_owner = (m_last + k) % N;
            end
            if (start_ok) begin
                m_col  = s_clr_col;
                m_busy = 1'b1;
                if (!took) m_pend = 1'b1;
            end
            m_done = nxt_done;
        end

        // requesters react to their own acceptance
        for (int i = 0; i < N; i++) begin
            if (s_req[i] && obs_wait[i] === 1'b0) begin
                if (rand_mode && $urandom_range(1) == 1) begin
                    s_x[i*4 +: 4]   = 4'($urandom_range(15));
                    s_y[i*4 +: 4]   = 4'($urandom_range(15));
                    s_col[i*3 +: 3] = 3'($urandom_range(7));
                end else if (rand_mode || !persist[i]) begin
                    s_req[i] = 1'b0;
                end
            end else if (!s_req[i] && rand_mode && $urandom_range(3) == 0) begin
                s_req[i]        = 1'b1;
                s_x[i*4 +: 4]   = 4'($urandom_range(15));
                s_y[i*4 +: 4]   = 4'($urandom_range(15));
                s_col[i*3 +: 3] = 3'($urandom_range(7));
            end
        end
        s_clr_start = 1'b0;
        s_rst       = 1'b0;
    endtask

    task automatic clear_stats();
        acc_total       = 0;
        clr_acc         = 0;
        done_cnt        = 0;
        done_cyc        = -1;
        last_clr_cyc    = -1;
        clr_col_mask    = 0;
        plot_req_cycles = 0;
        first_clr_x     = -1;
        first_clr_y     = -1;
        last_clr_x      = -1;
        last_clr_y      = -1;
        who_q.delete();
    endtask

    task automatic do_reset();
        s_req   = '0;
        persist = '0;
        s_rst   = 1'b1;
        cycle();
        plot_cnt = 0;
        clear_stats();
    endtask

    task automatic run_until(input int kind, input int target, input int budget, input string tag);
        int n = 0;
        while (stat(kind) < target && n < budget) begin
            cycle();
            n++;
        end
        check_val(tag, 32'(stat(kind) >= target), 32'd1);
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        int prc, n0;

        // single request and reset state
        do_reset();
        cycle();
        check_val("rst_plot_req",   32'(obs_req),  32'd0);
        check_val("rst_plot_xy",    32'({obs_x, obs_y, obs_col}), 32'd0);
        check_val("rst_req_wait",   32'(obs_wait), 32'd0);
        check_val("rst_clear_busy", 32'(obs_busy), 32'd0);
        check_val("rst_clear_done", 32'(obs_done), 32'd0);
        s_req[0]   = 1'b1;
        s_x[3:0]   = 4'd3;
        s_y[3:0]   = 4'd4;
        s_col[2:0] = 3'd5;
        cycle();
        check_val("t1_wait_c0", 32'(obs_wait[0]), 32'd1);
        cycle();
        check_val("t1_plot_req", 32'(obs_req), 32'd1);
        check_val("t1_plot_x",   32'(obs_x),   32'd3);
        check_val("t1_plot_y",   32'(obs_y),   32'd4);
        check_val("t1_colour",   32'(obs_col), 32'd5);
        check_val("t1_wait_c1",  32'(obs_wait[0]), 32'd0);
        check_val("t1_accepts",  32'(acc_total), 32'd1);
        prc = plot_req_cycles;
        repeat (BUSY) cycle();
        check_val("t1_quiet", 32'(plot_req_cycles - prc), 32'd0);

        // fairness between two continuously requesting clients
        do_reset();
        persist[1:0] = 2'b11;
        s_req[1:0]   = 2'b11;
        s_x[7:0]     = 8'h21;
        s_y[7:0]     = 8'h65;
        s_col[5:0]   = {GREEN, RED};
        run_until(3, 6, 6 * (BUSY + 4), "t2_timeout");
        for (int k = 0; k < 6; k++) check_val("t2_order", 32'(q_at(k)), 32'(k % 2));
        persist = '0;
        s_req   = '0;
        repeat (BUSY + 2) cycle();

        // full clear sweep, requester 2 stalled until it is done
        do_reset();
        s_clr_start = 1'b1;
        s_clr_col   = BLACK;
        cycle();
        repeat (10) cycle();
        s_req[2]   = 1'b1;
        s_x[11:8]  = 4'd7;
        s_y[11:8]  = 4'd8;
        s_col[8:6] = WHITE;
        run_until(2, 1, CELLS * (BUSY + 2), "t3_timeout");
        check_val("t3_clr_accepts", 32'(clr_acc), 32'(CELLS));
        check_val("t3_first_xy",    32'({first_clr_x[3:0], first_clr_y[3:0]}), 32'h00);
        check_val("t3_last_xy",     32'({last_clr_x[3:0], last_clr_y[3:0]}), 32'hff);
        check_val("t3_done_once",   32'(done_cnt), 32'd1);
        check_val("t3_done_timing", 32'(done_cyc), 32'(last_clr_cyc + 1));
        check_val("t3_colour",      32'(clr_col_mask), 32'd1);
        check_val("t3_req2_held",   32'(who_q.size()), 32'd0);
        run_until(3, 1, 2 * BUSY + 8, "t3_req2_timeout");
        check_val("t3_req2_served", 32'(q_at(0)), 32'd2);
        repeat (BUSY + 2) cycle();

        // clear during ISSUE, then an ignored restart at count 50
        do_reset();
        s_req[2]   = 1'b1;
        s_x[11:8]  = 4'd9;
        s_y[11:8]  = 4'd10;
        s_col[8:6] = 3'd6;
        plot_cnt   = 5;
        cycle();
        s_clr_start = 1'b1;
        s_clr_col   = 3'd3;
        cycle();
        check_val("t4_issue_req",  32'(obs_req), 32'd1);
        check_val("t4_issue_wait", 32'(obs_wait[2]), 32'd1);
        run_until(1, 1, 2 * BUSY + 16, "t4_timeout");
        check_val("t4_req2_first", 32'(q_at(0)), 32'd2);
        check_val("t4_clr_origin", 32'({first_clr_x[3:0], first_clr_y[3:0]}), 32'h00);
        run_until(1, 50, 50 * (BUSY + 2), "t5_count50_timeout");
        s_clr_start = 1'b1;
        s_clr_col   = WHITE;
        cycle();
        run_until(2, 1, CELLS * (BUSY + 2), "t5_timeout");
        check_val("t5_clr_accepts", 32'(clr_acc), 32'(CELLS));
        check_val("t5_colour",      32'(clr_col_mask), 32'h8);
        check_val("t5_done_once",   32'(done_cnt), 32'd1);
        repeat (BUSY + 2) cycle();

        // reset in the middle of a clear
        do_reset();
        s_clr_start = 1'b1;
        s_clr_col   = RED;
        cycle();
        run_until(1, 100, 100 * (BUSY + 2), "t6_timeout");
        s_rst = 1'b1;
        cycle();
        cycle();
        check_val("t6_plot_req",   32'(obs_req),  32'd0);
        check_val("t6_clear_busy", 32'(obs_busy), 32'd0);
        n0 = who_q.size();
        s_req[0]    = 1'b1;
        s_req[3]    = 1'b1;
        s_x[15:12]  = 4'd12;
        s_y[15:12]  = 4'd13;
        s_col[11:9] = 3'd1;
        run_until(3, n0 + 2, 3 * (BUSY + 4), "t6_req_timeout");
        check_val("t6_first_grant",  32'(q_at(n0)), 32'd0);
        check_val("t6_second_grant", 32'(q_at(n0 + 1)), 32'd3);

        // randomized soak against the reference model
        do_reset();
        rand_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) busy_len = $urandom_range(3);
            if ($urandom_range(299) == 0) begin
                s_clr_start = 1'b1;
                s_clr_col   = 3'($urandom_range(7));
            end
            if ($urandom_range(1999) == 0) s_rst = 1'b1;
            cycle();
        end
        check_val("rand_activity", 32'(acc_total > 100), 32'd1);
        rand_mode = 1'b0;
        busy_len  = BUSY;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single 16x16 game-grid cell plotter (game_plot / waitrequest interface) between N game-logic requesters and an internal board-clear sequencer.
- Requesters include the snake head painter, tail eraser, food placer and score/flash effects.
- The block sits between the game FSMs and the cell plotter, and uses round-robin arbitration.
- A board clear has priority at each arbitration point and sweeps all 256 cells with one colour.

Parameters:
- N, 4, number of requesters (2..8).
- GRID, 16, cells per axis. The cell counter is 2*log2(GRID) bits wide.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- req  in  N  per-requester plot request; held until that requester's req_wait is low
- req_x  in  4*N  cell x, packed; requester i uses bits [4i+3:4i]
- req_y  in  4*N  cell y, packed the same way
- req_colour  in  3*N  colour, packed; requester i uses bits [3i+2:3i]
- req_wait  out  N  req_wait[i] = req[i] && !accept_i
- clear_start  in  1  one-cycle pulse that starts a board clear
- clear_colour  in  3  clear colour, sampled on clear_start
- clear_busy  out  1  high while a clear is pending or running
- clear_done  out  1  one-cycle pulse in the cycle after the last clear plot is accepted
- plot_req  out  1  drives the plotter's game_plot
- plot_x  out  4  drives the plotter's game_x
- plot_y  out  4  drives the plotter's game_y
- plot_colour  out  3  drives the plotter's game_colour
- plot_waitrequest  in  1  the plotter's waitrequest

Behaviour:
- Reset:
  - state = IDLE.
  - plot_req, plot_x, plot_y, plot_colour = 0.
  - req_wait = 0, clear_busy = 0, clear_done = 0.
  - Clear pending and clear counter cleared.
  - rr_last = N-1, so requester 0 wins first.
  - Reset mid-operation abandons the current plot or clear; no resumption.
- Accept:
  - A downstream transfer is accepted in a cycle where plot_req && !plot_waitrequest.
  - The plotter accepts in its idle cycle, then holds waitrequest high for 36 cycles.
- State IDLE:
  - plot_req = 0; plot_x/plot_y/plot_colour = 0.
  - If clear is pending: go to CLEAR.
  - Else if any req is high: grant the first requester with req high, searching rr_last+1 .. rr_last modulo N. Register grant and go to ISSUE.
- State ISSUE:
  - plot_req = 1; plot_x/y/colour are combinational muxes of the granted requester's fields.
  - On accept: req_wait[grant] = 0 that cycle, rr_last <= grant, go to IDLE.
  - The arbitration cost is one IDLE cycle between grants.
- State CLEAR:
  - plot_req = 1; plot_x = cnt[3:0], plot_y = cnt[7:4]; plot_colour = latched clear_colour.
  - Sweep is row-major: (0,0), (1,0) .. (15,15).
  - On accept: cnt++. On accept at cnt = 255: go to IDLE, clear_busy <= 0, clear_done <= 1 for one cycle.
- Clear start rules:
  - clear_start while clear_busy = 1 is ignored; colour is not re-sampled.
  - clear_start during ISSUE does not abort the ISSUE. The clear starts at the next IDLE and pre-empts all requesters.
- Requests during a clear:
  - Requests raised during CLEAR stall with req_wait high.
  - rr_last is unchanged by a clear.
- req low: req_wait[i] = 0 whenever req[i] = 0.
- Requester rule: a requester must not change x/y/colour while its req_wait is high.
- Grant stability: grant does not change while in ISSUE, even if the granted req drops (protocol violation). The issued values are whatever is then on that requester's inputs.
- Latency: with an idle plotter, req rises in cycle 0, plot_req and accept occur in cycle 1, and req_wait[i] is low in cycle 1.

Decomposition:
- Package game_pkg:
  - GRID_DIM = 16, CELL_W = 4, COLOUR_W = 3.
  - Colour constants: BLACK = 3'b000, GREEN = 3'b010, RED = 3'b100, WHITE = 3'b111.
  - arb_state_t enum {IDLE, ISSUE, CLEAR}.
- Sub-module rr_select: combinational round-robin priority picker; inputs req[N] and rr_last; outputs grant index and valid. The sweep counter stays inline.

Test Plan:
- Single request: after reset, req[0] = 1 with x = 3, y = 4, colour = 5 → cycle 1 has plot_req = 1, plot_x = 3, plot_y = 4, plot_colour = 5, and req_wait[0] = 0. plot_req then stays 0 for the plotter's 36-cycle busy period.
- Fairness: req[0] and req[1] held high continuously → grant order 0, 1, 0, 1, 0, 1. Exactly one accept per plotter idle window; req_wait of the waiting requester stays 1.
- Clear sweep: clear_start with clear_colour = 0 → exactly 256 accepts, first at (0,0) and last at (15,15). clear_done pulses once, one cycle after the last accept; clear_busy = 1 throughout. req[2] held during the clear is served only after clear_done.
- Clear during ISSUE: req[2] is granted and waiting on plot_waitrequest = 1 when clear_start pulses → req[2] is accepted first, then the clear begins at (0,0).
- Ignored restart: clear_start = 1 again at clear count 50 with clear_colour = 7 → the sweep continues with the original colour and the total is still 256 accepts.
- Reset mid-clear: rst = 1 at clear count 100 → next cycle plot_req = 0 and clear_busy = 0. After release, req[0] and req[3] high → requester 0 is granted first.
